// File: rtl/uart_rx_parity_check.sv
// rtl/uart_rx_parity_check.sv - UART receiver with mid-bit sampling, parity/stop checking and valid/ack hand-off
module uart_rx_parity_check #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    input  logic                  parity_en,
    input  logic                  is_even_parity,
    input  logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  overrun_error,
    output logic                  rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_next;
    logic                    rx_meta, rx_s;
    logic [TW-1:0]           tick_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_bit;
    logic                    cfg_par_en, cfg_even;
    logic                    mid_start, bit_end, last_data;
    logic                    frame_done, expected_par, par_err;

    assign mid_start = (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign bit_end   = (tick_cnt == TW'(OVERSAMPLE - 1));
    assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (baud_tick) begin
            case (state)
                IDLE:    if (!rx_s) state_next = START;
                START:   if (mid_start) state_next = rx_s ? IDLE : DATA;
                DATA:    if (bit_end && last_data) state_next = cfg_par_en ? PARITY : STOP;
                PARITY:  if (bit_end) state_next = STOP;
                STOP:    if (bit_end) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy    = (state != IDLE);
        frame_done = baud_tick && (state == STOP) && bit_end;
    end

    // Timing counters and the frame datapath only move on baud ticks.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            cfg_par_en <= 1'b0;
            cfg_even   <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                IDLE: tick_cnt <= '0;
                START: begin
                    if (mid_start) begin
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
                        cfg_par_en <= parity_en;
                        cfg_even   <= is_even_parity;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA, PARITY, STOP: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (state == DATA) begin
                            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                            bit_cnt   <= bit_cnt + BW'(1);
                        end
                        if (state == PARITY) par_bit <= rx_s;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: tick_cnt <= '0;
            endcase
        end
    end

    assign expected_par = cfg_even ? (^shift_reg) : ~(^shift_reg);
    assign par_err      = cfg_par_en && (par_bit != expected_par);

    // A completing frame wins over a plain ack; an ack in the same cycle frees the holding slot.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else if (frame_done) begin
            if (!rx_valid || rx_ack) begin
                rx_data       <= shift_reg;
                rx_valid      <= 1'b1;
                parity_error  <= par_err;
                framing_error <= ~rx_s;
                if (rx_ack) overrun_error <= 1'b0;
            end else begin
                overrun_error <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_parity_check.sv
// tb/tb_uart_rx_parity_check.sv - scoreboard bench for uart_rx_parity_check
module tb_uart_rx_parity_check;

    localparam int OS = 16;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity_en = 1'b0;
    logic       is_even_parity = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, framing_error, overrun_error, rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;
    logic prev_ack = 1'b0;

    uart_rx_parity_check #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .baud_tick(baud_tick), .rx_in(rx_in),
        .parity_en(parity_en), .is_even_parity(is_even_parity), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
        .framing_error(framing_error), .overrun_error(overrun_error), .rx_busy(rx_busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a frame is presented when rx_valid rises, or stays high right after an ack cycle.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            prev_valid <= 1'b0;
            prev_ack   <= 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got data 0x%0h with empty scoreboard", rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame {data,perr,ferr,ovr}",
                          int'({rx_data, parity_error, framing_error, overrun_error}),
                          int'({mon_e.data, mon_e.perr, mon_e.ferr, mon_e.ovr}));
                end
            end
            prev_valid <= rx_valid;
            prev_ack   <= rx_ack;
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_q.push_back('{data: d, perr: p, ferr: f, ovr: o});
    endtask

    task automatic tick_cycle(input bit ack);
        baud_tick = 1'b1;
        rx_ack    = ack;
        @(posedge HCLK); #1;
        baud_tick = 1'b0;
        rx_ack    = 1'b0;
        @(posedge HCLK); #1;
    endtask

    task automatic idle_ticks(input int n);
        rx_in = 1'b1;
        repeat (n) tick_cycle(1'b0);
    endtask

    // The receiver samples each bit at tick 9 of the bit; ack_mid lands on the stop-sampling cycle.
    task automatic send_bit(input logic v, input bit ack_mid);
        rx_in = v;
        for (int i = 0; i < OS; i++) tick_cycle(ack_mid && (i == 9));
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_v,
                              input logic stop_v, input bit ack_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        if (with_par) send_bit(par_v, 1'b0);
        send_bit(stop_v, ack_stop);
        rx_in = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge HCLK); #1;
        rx_ack = 1'b0;
        check("ack_clears_valid", int'(rx_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit busy_seen;
        repeat (3) @(posedge HCLK);
        #1;
        check("reset_valid", int'(rx_valid), 0);
        check("reset_data", int'(rx_data), 0);
        check("reset_flags", int'({parity_error, framing_error, overrun_error}), 0);
        check("reset_busy", int'(rx_busy), 0);
        HRESETn = 1'b1;
        idle_ticks(4);

        // Even parity, 0x41 has two ones -> parity bit 0 is correct
        parity_en = 1'b1; is_even_parity = 1'b1;
        push_exp(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        check("t1_valid_held", int'(rx_valid), 1);
        pulse_ack();
        idle_ticks(20);

        // Odd parity: 0x41 needs parity bit 1
        is_even_parity = 1'b0;
        push_exp(8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        pulse_ack();
        idle_ticks(4);
        push_exp(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_ticks(4);
        pulse_ack();
        idle_ticks(4);

        // No parity, bad stop bit, then a good frame
        parity_en = 1'b0;
        push_exp(8'hA5, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_ticks(20);
        check("t3_busy_after_recover", int'(rx_busy), 0);
        pulse_ack();
        push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        pulse_ack();
        idle_ticks(4);

        // False start: 4 ticks low
        busy_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx_in = (i < 4) ? 1'b0 : 1'b1;
            tick_cycle(1'b0);
            if (rx_busy) busy_seen = 1'b1;
        end
        check("t4_busy_seen", int'(busy_seen), 1);
        check("t4_busy_end", int'(rx_busy), 0);
        check("t4_no_valid", int'(rx_valid), 0);
        idle_ticks(4);

        // Overrun: second frame dropped
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        check("t5_ovr_valid", int'(rx_valid), 1);
        check("t5_ovr_data", int'(rx_data), 'h11);
        check("t5_ovr_flag", int'(overrun_error), 1);
        pulse_ack();
        check("t5_ovr_cleared", int'(overrun_error), 0);
        idle_ticks(4);

        // Ack coincident with completion of 0x22
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        push_exp(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_ticks(2);
        check("t5_ack_data", int'(rx_data), 'h22);
        check("t5_ack_valid", int'(rx_valid), 1);
        check("t5_ack_ovr", int'(overrun_error), 0);

        // Reset after the 4th data bit of 0xFF, with 0x22 still held
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        check("t6_busy_before", int'(rx_busy), 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("t6_rst_valid", int'(rx_valid), 0);
        check("t6_rst_data", int'(rx_data), 0);
        check("t6_rst_flags", int'({parity_error, framing_error, overrun_error}), 0);
        check("t6_rst_busy", int'(rx_busy), 0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle_ticks(20);
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        pulse_ack();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
